// File: rtl/accel_core_weight_feeder.sv
// Weight-buffer producer for accel_core_mul_top: streams neuron rows into w1..w3 round-robin.
// Define ACCEL_WFEED_STATS_EN to add the stall_cycles_o counter.
package accel_core_weight_feeder_pkg;
    localparam int WBUF_DEPTH = 16;

    typedef struct packed {
        logic       in_use;
        logic [7:0] neuron_idx;
        logic [7:0] data_len;
    } t_meta_data;

    typedef struct packed {
        t_meta_data                 meta_data;
        logic [WBUF_DEPTH-1:0][7:0] data;
    } t_buffer_weights;

    typedef enum logic [1:0] {SLOT_EMPTY, SLOT_FILLING, SLOT_ARMED} slot_st_e;
endpackage

// One weight buffer: EMPTY -> FILLING -> ARMED -> EMPTY.
module accel_core_weight_feeder_slot
    import accel_core_weight_feeder_pkg::*;
#(
    parameter int IW = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            wr_en_i,
    input  logic [IW-1:0]   wr_idx_i,
    input  logic [7:0]      wr_data_i,
    input  logic            arm_i,
    input  logic [7:0]      arm_len_i,
    input  logic [7:0]      arm_idx_i,
    input  logic            release_i,
    output t_buffer_weights buf_o,
    output slot_st_e        st_o
);
    t_buffer_weights buf_q, buf_d;
    slot_st_e        st_q, st_d;

    always_comb begin
        buf_d = buf_q;
        st_d  = st_q;
        if (wr_en_i) begin
            buf_d.data[wr_idx_i] = wr_data_i;
            if (st_q == SLOT_EMPTY) st_d = SLOT_FILLING;
        end
        if (arm_i) begin
            buf_d.meta_data.in_use     = 1'b1;
            buf_d.meta_data.data_len   = arm_len_i;
            buf_d.meta_data.neuron_idx = arm_idx_i;
            st_d = SLOT_ARMED;
        end else if (release_i && st_q == SLOT_ARMED) begin
            // Payload is left in place; only the handshake flag drops.
            buf_d.meta_data.in_use = 1'b0;
            st_d = SLOT_EMPTY;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            buf_q <= '0;
            st_q  <= SLOT_EMPTY;
        end else begin
            buf_q <= buf_d;
            st_q  <= st_d;
        end
    end

    assign buf_o = buf_q;
    assign st_o  = st_q;
endmodule

module accel_core_weight_feeder
    import accel_core_weight_feeder_pkg::*;
#(
    parameter int MAX_LEN  = 16,
    parameter int NEURON_W = 8
) (
    input  logic                Clock_i,
    input  logic                Rst_i,
    input  logic                layer_start_i,
    input  logic [NEURON_W-1:0] num_neurons_i,
    input  logic                wr_valid_i,
    output logic                wr_ready_o,
    input  logic [7:0]          wr_data_i,
    input  logic                wr_last_i,
    output t_buffer_weights     w1_o,
    output t_buffer_weights     w2_o,
    output t_buffer_weights     w3_o,
    input  logic                release_w1_i,
    input  logic                release_w2_i,
    input  logic                release_w3_i,
    output logic                layer_loaded_o,
    output logic                busy_o,
    output logic                err_overflow_o
`ifdef ACCEL_WFEED_STATS_EN
    ,
    output logic [15:0]         stall_cycles_o
`endif
);
    localparam int EW = $clog2(MAX_LEN) + 1;
    localparam int IW = $clog2(WBUF_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_DRAIN} fsm_e;

    fsm_e                fsm_q, fsm_d;
    logic [1:0]          tgt_q, tgt_d;
    logic [NEURON_W-1:0] num_q, num_d, ncnt_q, ncnt_d;
    logic [EW-1:0]       ecnt_q, ecnt_d;
    logic                drop_q, drop_d, rdy_q, rdy_d;
    logic                loaded_q, loaded_d, ovf_q, ovf_d;
    logic                accept, wr_en, all_empty;
    logic [2:0]          arm, rel;
    logic [IW-1:0]       widx;
    t_buffer_weights     bufs [3];
    slot_st_e            st [3];
    slot_st_e            st_norel [3];

    assign rel  = {release_w3_i, release_w2_i, release_w1_i};
    assign widx = IW'(ecnt_q);

    for (genvar g = 0; g < 3; g++) begin : g_slot
        accel_core_weight_feeder_slot #(.IW(IW)) u_slot (
            .clk_i     (Clock_i),
            .rst_i     (Rst_i),
            .wr_en_i   (wr_en && tgt_q == 2'(g)),
            .wr_idx_i  (widx),
            .wr_data_i (wr_data_i),
            .arm_i     (arm[g]),
            .arm_len_i (8'(ecnt_q) + 8'd1),
            .arm_idx_i (8'(ncnt_q)),
            .release_i (rel[g]),
            .buf_o     (bufs[g]),
            .st_o      (st[g])
        );
    end

    always_comb begin
        fsm_d    = fsm_q;
        tgt_d    = tgt_q;
        num_d    = num_q;
        ncnt_d   = ncnt_q;
        ecnt_d   = ecnt_q;
        drop_d   = drop_q;
        ovf_d    = ovf_q;
        loaded_d = 1'b0;
        arm      = '0;
        accept   = wr_valid_i && rdy_q;
        wr_en    = accept && !drop_q && fsm_q == S_FILL;
        all_empty = st[0] == SLOT_EMPTY && st[1] == SLOT_EMPTY && st[2] == SLOT_EMPTY;

        if (accept && drop_q && wr_last_i) drop_d = 1'b0;

        if (wr_en) begin
            ecnt_d = ecnt_q + EW'(1);
            if (wr_last_i || ecnt_q == EW'(MAX_LEN - 1)) begin
                arm[tgt_q] = 1'b1;
                ecnt_d     = '0;
                ncnt_d     = ncnt_q + NEURON_W'(1);
                tgt_d      = (tgt_q == 2'd2) ? 2'd0 : tgt_q + 2'd1;
                // Row cut at capacity: swallow the tail up to the bias.
                if (!wr_last_i) begin
                    ovf_d  = 1'b1;
                    drop_d = 1'b1;
                end
                if (ncnt_q + NEURON_W'(1) == num_q) begin
                    loaded_d = 1'b1;
                    fsm_d    = S_DRAIN;
                end
            end
        end

        case (fsm_q)
            S_IDLE: begin
                if (layer_start_i) begin
                    if (num_neurons_i != '0) begin
                        num_d  = num_neurons_i;
                        ncnt_d = '0;
                        ecnt_d = '0;
                        fsm_d  = S_FILL;
                    end else begin
                        loaded_d = 1'b1;
                    end
                end
            end
            S_DRAIN: if (all_empty && !drop_q) fsm_d = S_IDLE;
            default: ;
        endcase

        // Ready looks at next state but deliberately ignores this cycle's releases.
        for (int k = 0; k < 3; k++) st_norel[k] = arm[k] ? SLOT_ARMED : st[k];
        rdy_d = drop_d || (fsm_d == S_FILL && ncnt_d != num_d && st_norel[tgt_d] != SLOT_ARMED);
    end

    always_ff @(posedge Clock_i) begin
        if (Rst_i) begin
            fsm_q    <= S_IDLE;
            tgt_q    <= '0;
            num_q    <= '0;
            ncnt_q   <= '0;
            ecnt_q   <= '0;
            drop_q   <= 1'b0;
            rdy_q    <= 1'b0;
            loaded_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            fsm_q    <= fsm_d;
            tgt_q    <= tgt_d;
            num_q    <= num_d;
            ncnt_q   <= ncnt_d;
            ecnt_q   <= ecnt_d;
            drop_q   <= drop_d;
            rdy_q    <= rdy_d;
            loaded_q <= loaded_d;
            ovf_q    <= ovf_d;
        end
    end

`ifdef ACCEL_WFEED_STATS_EN
    logic [15:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (fsm_q == S_IDLE && layer_start_i)
            stall_d = '0;
        else if (fsm_q == S_FILL && wr_valid_i && !rdy_q && stall_q != 16'hFFFF)
            stall_d = stall_q + 16'd1;
    end

    always_ff @(posedge Clock_i) begin
        if (Rst_i) stall_q <= '0;
        else       stall_q <= stall_d;
    end

    assign stall_cycles_o = stall_q;
`endif

    assign w1_o           = bufs[0];
    assign w2_o           = bufs[1];
    assign w3_o           = bufs[2];
    assign wr_ready_o     = rdy_q;
    assign busy_o         = fsm_q != S_IDLE;
    assign layer_loaded_o = loaded_q;
    assign err_overflow_o = ovf_q;
endmodule

// File: tb/tb_accel_core_weight_feeder.sv
// Directed bench: a MAX_LEN=16 instance for the main flows and a MAX_LEN=4 instance for overflow.
module tb_accel_core_weight_feeder;
    import accel_core_weight_feeder_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, sel, ls, wv, wl, r1, r2, r3;
    logic [7:0] num, wd;
    logic rdy_a, rdy_b, busy_a, busy_b, ld_a, ld_b, err_a, err_b;
    logic rdy, busy, loaded, err;
    t_buffer_weights w1a, w2a, w3a, w1b, w2b, w3b, w1, w2, w3;
    int total = 0;
    int bad = 0;
`ifdef ACCEL_WFEED_STATS_EN
    logic [15:0] stall_a, stall_b;
`endif

    accel_core_weight_feeder #(.MAX_LEN(16), .NEURON_W(8)) dut_a (
        .Clock_i(clk), .Rst_i(rst), .layer_start_i(ls && !sel), .num_neurons_i(num),
        .wr_valid_i(wv && !sel), .wr_ready_o(rdy_a), .wr_data_i(wd), .wr_last_i(wl),
        .w1_o(w1a), .w2_o(w2a), .w3_o(w3a),
        .release_w1_i(r1 && !sel), .release_w2_i(r2 && !sel), .release_w3_i(r3 && !sel),
        .layer_loaded_o(ld_a), .busy_o(busy_a), .err_overflow_o(err_a)
`ifdef ACCEL_WFEED_STATS_EN
        , .stall_cycles_o(stall_a)
`endif
    );

    accel_core_weight_feeder #(.MAX_LEN(4), .NEURON_W(8)) dut_b (
        .Clock_i(clk), .Rst_i(rst), .layer_start_i(ls && sel), .num_neurons_i(num),
        .wr_valid_i(wv && sel), .wr_ready_o(rdy_b), .wr_data_i(wd), .wr_last_i(wl),
        .w1_o(w1b), .w2_o(w2b), .w3_o(w3b),
        .release_w1_i(r1 && sel), .release_w2_i(r2 && sel), .release_w3_i(r3 && sel),
        .layer_loaded_o(ld_b), .busy_o(busy_b), .err_overflow_o(err_b)
`ifdef ACCEL_WFEED_STATS_EN
        , .stall_cycles_o(stall_b)
`endif
    );

    always_comb begin
        w1 = sel ? w1b : w1a;
        w2 = sel ? w2b : w2a;
        w3 = sel ? w3b : w3a;
    end
    assign rdy    = sel ? rdy_b  : rdy_a;
    assign busy   = sel ? busy_b : busy_a;
    assign loaded = sel ? ld_b   : ld_a;
    assign err    = sel ? err_b  : err_a;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic start_layer(input logic [7:0] n);
        ls = 1'b1; num = n;
        tick();
        ls = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic last);
        int n = 0;
        wv = 1'b1; wd = d; wl = last;
        while (!rdy && n < 50) begin tick(); n++; end
        total++;
        if (rdy !== 1'b1) begin bad++; $display("FAIL send_byte_ready data=%0h got=%0b want=1", d, rdy); end
        tick();
        wv = 1'b0; wl = 1'b0;
    endtask

    task automatic pulse_rel(input logic [2:0] m);
        {r3, r2, r1} = m;
        tick();
        {r3, r2, r1} = 3'b000;
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        while (busy && n < 50) begin tick(); n++; end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL %s_idle got=%0b want=0", nm, busy); end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        total++; if (rdy !== 1'b0) begin bad++; $display("FAIL reset_ready got=%0b want=0", rdy); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b want=0", busy); end
        total++; if (loaded !== 1'b0) begin bad++; $display("FAIL reset_loaded got=%0b want=0", loaded); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%0b want=0", err); end
        total++; if ({w1, w2, w3} !== '0) begin bad++; $display("FAIL reset_bufs got=%0h want=0", {w1, w2, w3}); end
    endtask

    task automatic test_rows();
        start_layer(8'd3);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL rows_busy got=%0b want=1", busy); end
        send_byte(8'h03, 1'b0);
        send_byte(8'h04, 1'b0);
        total++; if (w1.meta_data.in_use !== 1'b0) begin bad++; $display("FAIL rows_w1_early got=%0b want=0", w1.meta_data.in_use); end
        send_byte(8'h05, 1'b1);
        total++; if (w1.meta_data.in_use !== 1'b1) begin bad++; $display("FAIL rows_w1_inuse got=%0b want=1", w1.meta_data.in_use); end
        total++; if (w1.data[2:0] !== {8'h05, 8'h04, 8'h03}) begin bad++; $display("FAIL rows_w1_data got=%0h want=050403", w1.data[2:0]); end
        total++; if ({w1.meta_data.data_len, w1.meta_data.neuron_idx} !== {8'd3, 8'd0}) begin bad++; $display("FAIL rows_w1_meta got=%0h want=0300", {w1.meta_data.data_len, w1.meta_data.neuron_idx}); end
        send_byte(8'h06, 1'b0);
        send_byte(8'h07, 1'b0);
        send_byte(8'h08, 1'b1);
        total++; if (loaded !== 1'b0) begin bad++; $display("FAIL rows_loaded_early got=%0b want=0", loaded); end
        total++; if ({w2.meta_data.in_use, w2.meta_data.data_len, w2.meta_data.neuron_idx, w2.data[2:0]} !== {1'b1, 8'd3, 8'd1, 8'h08, 8'h07, 8'h06}) begin
            bad++; $display("FAIL rows_w2 got=%0h want=%0h", {w2.meta_data.in_use, w2.meta_data.data_len, w2.meta_data.neuron_idx, w2.data[2:0]}, {1'b1, 8'd3, 8'd1, 8'h08, 8'h07, 8'h06});
        end
        send_byte(8'h09, 1'b0);
        send_byte(8'h0A, 1'b0);
        send_byte(8'h0B, 1'b1);
        total++; if ({w3.meta_data.in_use, w3.meta_data.data_len, w3.meta_data.neuron_idx, w3.data[2:0]} !== {1'b1, 8'd3, 8'd2, 8'h0B, 8'h0A, 8'h09}) begin
            bad++; $display("FAIL rows_w3 got=%0h want=%0h", {w3.meta_data.in_use, w3.meta_data.data_len, w3.meta_data.neuron_idx, w3.data[2:0]}, {1'b1, 8'd3, 8'd2, 8'h0B, 8'h0A, 8'h09});
        end
        total++; if (loaded !== 1'b1) begin bad++; $display("FAIL rows_loaded got=%0b want=1", loaded); end
        tick();
        total++; if (loaded !== 1'b0) begin bad++; $display("FAIL rows_loaded_once got=%0b want=0", loaded); end
        total++; if ({busy, rdy} !== 2'b10) begin bad++; $display("FAIL rows_drain busy_rdy=%0b want=10", {busy, rdy}); end
    endtask

    task automatic test_drain();
        pulse_rel(3'b111);
        total++; if ({w1.meta_data.in_use, w2.meta_data.in_use, w3.meta_data.in_use} !== 3'b000) begin
            bad++; $display("FAIL drain_inuse got=%0b want=000", {w1.meta_data.in_use, w2.meta_data.in_use, w3.meta_data.in_use});
        end
        total++; if ({w1.meta_data.data_len, w1.data[0]} !== {8'd3, 8'h03}) begin bad++; $display("FAIL drain_hold got=%0h want=0303", {w1.meta_data.data_len, w1.data[0]}); end
        tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL drain_busy got=%0b want=0", busy); end
    endtask

    task automatic test_recycle();
        start_layer(8'd4);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL recycle_start got=%0b want=1", busy); end
        send_byte(8'h11, 1'b1);
        send_byte(8'h21, 1'b1);
        send_byte(8'h31, 1'b1);
        wv = 1'b1; wd = 8'h41; wl = 1'b0;
        repeat (2) tick();
        total++; if (rdy !== 1'b0) begin bad++; $display("FAIL recycle_stall got=%0b want=0", rdy); end
        pulse_rel(3'b001);
        total++; if ({w1.meta_data.in_use, rdy} !== 2'b00) begin bad++; $display("FAIL recycle_release inuse_rdy=%0b want=00", {w1.meta_data.in_use, rdy}); end
        tick();
        total++; if (rdy !== 1'b1) begin bad++; $display("FAIL recycle_ready got=%0b want=1", rdy); end
        send_byte(8'h41, 1'b0);
        send_byte(8'h42, 1'b1);
        total++; if ({w1.meta_data.in_use, w1.meta_data.data_len, w1.meta_data.neuron_idx, w1.data[1:0]} !== {1'b1, 8'd2, 8'd3, 8'h42, 8'h41}) begin
            bad++; $display("FAIL recycle_w1 got=%0h want=%0h", {w1.meta_data.in_use, w1.meta_data.data_len, w1.meta_data.neuron_idx, w1.data[1:0]}, {1'b1, 8'd2, 8'd3, 8'h42, 8'h41});
        end
        total++; if (loaded !== 1'b1) begin bad++; $display("FAIL recycle_loaded got=%0b want=1", loaded); end
        pulse_rel(3'b111);
        wait_idle("recycle");
    endtask

    task automatic test_overflow();
        sel = 1'b1;
        start_layer(8'd2);
        send_byte(8'h11, 1'b0);
        send_byte(8'h12, 1'b0);
        send_byte(8'h13, 1'b0);
        send_byte(8'h14, 1'b0);
        total++; if ({err, w1.meta_data.in_use, w1.meta_data.data_len} !== {1'b1, 1'b1, 8'd4}) begin
            bad++; $display("FAIL ovf_arm got=%0h want=%0h", {err, w1.meta_data.in_use, w1.meta_data.data_len}, {1'b1, 1'b1, 8'd4});
        end
        send_byte(8'h15, 1'b0);
        send_byte(8'h16, 1'b1);
        total++; if (w1.data[3:0] !== {8'h14, 8'h13, 8'h12, 8'h11}) begin bad++; $display("FAIL ovf_w1_data got=%0h want=14131211", w1.data[3:0]); end
        total++; if ({w2.meta_data.in_use, w2.data[0], w1.meta_data.data_len} !== {1'b0, 8'h00, 8'd4}) begin
            bad++; $display("FAIL ovf_dropped got=%0h want=%0h", {w2.meta_data.in_use, w2.data[0], w1.meta_data.data_len}, {1'b0, 8'h00, 8'd4});
        end
        send_byte(8'h21, 1'b0);
        send_byte(8'h22, 1'b1);
        total++; if ({w2.meta_data.in_use, w2.meta_data.data_len, w2.meta_data.neuron_idx, w2.data[1:0]} !== {1'b1, 8'd2, 8'd1, 8'h22, 8'h21}) begin
            bad++; $display("FAIL ovf_w2 got=%0h want=%0h", {w2.meta_data.in_use, w2.meta_data.data_len, w2.meta_data.neuron_idx, w2.data[1:0]}, {1'b1, 8'd2, 8'd1, 8'h22, 8'h21});
        end
        total++; if ({err, loaded} !== 2'b11) begin bad++; $display("FAIL ovf_sticky err_loaded=%0b want=11", {err, loaded}); end
        pulse_rel(3'b011);
        wait_idle("ovf");
        total++; if (err !== 1'b1) begin bad++; $display("FAIL ovf_sticky_idle got=%0b want=1", err); end
        sel = 1'b0;
    endtask

    task automatic test_reset_mid();
        start_layer(8'd3);
        send_byte(8'h51, 1'b0);
        send_byte(8'h52, 1'b1);
        send_byte(8'h61, 1'b0);
        send_byte(8'h62, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++; if ({w1, w2, w3} !== '0) begin bad++; $display("FAIL rstmid_bufs got=%0h want=0", {w1, w2, w3}); end
        total++; if ({busy, rdy, loaded, err} !== 4'b0000) begin bad++; $display("FAIL rstmid_flags got=%0b want=0000", {busy, rdy, loaded, err}); end
        pulse_rel(3'b010);
        tick();
        total++; if ({w2.meta_data.in_use, busy} !== 2'b00) begin bad++; $display("FAIL rstmid_spurious got=%0b want=00", {w2.meta_data.in_use, busy}); end
        start_layer(8'd1);
        send_byte(8'h71, 1'b0);
        send_byte(8'h72, 1'b1);
        total++; if ({w1.meta_data.in_use, w1.meta_data.data_len, w1.meta_data.neuron_idx, w1.data[1:0], w2.meta_data.in_use} !== {1'b1, 8'd2, 8'd0, 8'h72, 8'h71, 1'b0}) begin
            bad++; $display("FAIL rstmid_restart got=%0h want=%0h", {w1.meta_data.in_use, w1.meta_data.data_len, w1.meta_data.neuron_idx, w1.data[1:0], w2.meta_data.in_use}, {1'b1, 8'd2, 8'd0, 8'h72, 8'h71, 1'b0});
        end
        total++; if (loaded !== 1'b1) begin bad++; $display("FAIL rstmid_loaded got=%0b want=1", loaded); end
        pulse_rel(3'b001);
        wait_idle("rstmid");
    endtask

    task automatic test_stats();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        start_layer(8'd4);
        send_byte(8'h81, 1'b1);
        send_byte(8'h82, 1'b1);
        send_byte(8'h83, 1'b1);
        wv = 1'b1; wd = 8'h99; wl = 1'b0;
        repeat (7) tick();
        wv = 1'b0;
        total++; if (rdy !== 1'b0) begin bad++; $display("FAIL stats_stalled got=%0b want=0", rdy); end
`ifdef ACCEL_WFEED_STATS_EN
        total++; if (stall_a !== 16'd7) begin bad++; $display("FAIL stats_count got=%0d want=7", stall_a); end
`endif
        pulse_rel(3'b001);
        send_byte(8'h84, 1'b1);
        total++; if ({w1.meta_data.neuron_idx, w1.data[0]} !== {8'd3, 8'h84}) begin bad++; $display("FAIL stats_row4 got=%0h want=0384", {w1.meta_data.neuron_idx, w1.data[0]}); end
        pulse_rel(3'b111);
        wait_idle("stats");
    endtask

    task automatic test_empty_layer();
        start_layer(8'd0);
        total++; if ({loaded, busy} !== 2'b10) begin bad++; $display("FAIL empty_loaded loaded_busy=%0b want=10", {loaded, busy}); end
`ifdef ACCEL_WFEED_STATS_EN
        total++; if (stall_a !== 16'd0) begin bad++; $display("FAIL empty_stats_clear got=%0d want=0", stall_a); end
`endif
        tick();
        total++; if ({loaded, busy} !== 2'b00) begin bad++; $display("FAIL empty_once loaded_busy=%0b want=00", {loaded, busy}); end
    endtask

    initial begin
        rst = 1'b1; sel = 1'b0; ls = 1'b0; num = 8'd0;
        wv = 1'b0; wd = 8'h00; wl = 1'b0;
        r1 = 1'b0; r2 = 1'b0; r3 = 1'b0;
        test_reset();
        test_rows();
        test_drain();
        test_recycle();
        test_overflow();
        test_reset_mid();
        test_stats();
        test_empty_layer();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/accel_core_weight_feeder.md
Name: accel_core_weight_feeder

Overview:
- Producer side of the weight-buffer handshake consumed by accel_core_mul_top.
- Accepts a byte stream of per-neuron weight rows, with the bias as the last element of each row.
- Fills three t_buffer_weights buffers (w1, w2, w3) round-robin, arms each by setting meta_data.in_use, and recycles a buffer when the multiplier pulses the matching release_wN.
- Sits between the core's store path and accel_core_mul_top for one layer at a time.

Parameters:
- MAX_LEN, 16, maximum elements per weight row including bias; must not exceed the data array depth of t_buffer_weights.
- NEURON_W, 8, width of the neuron count and index.

Ports:
- Clock  input  1  clock
- Rst  input  1  synchronous active-high reset
- layer_start  input  1  one-cycle pulse; latches num_neurons and begins a layer
- num_neurons  input  NEURON_W  neurons in the layer (0 = empty layer)
- wr_valid  input  1  weight byte valid
- wr_ready  output  1  feeder accepts byte this cycle
- wr_data  input  8  weight or bias byte
- wr_last  input  1  marks the final element (bias) of a neuron row
- w1, w2, w3  output  t_buffer_weights  weight buffers to accel_core_mul_top
- release_w1, release_w2, release_w3  input  1  pulse from multiplier: buffer consumed
- layer_loaded  output  1  one-cycle pulse when the last neuron row is armed
- busy  output  1  layer in progress
- err_overflow  output  1  sticky; a row exceeded MAX_LEN

Behaviour:
- Clock and reset: one clock (Clock); Rst is synchronous and active-high.
- Reset: all of w1–w3 are zeroed, including data, data_len, neuron_idx and in_use. wr_ready=0, layer_loaded=0, busy=0, err_overflow=0. The top FSM goes to IDLE and the target pointer goes to w1.
- Reset mid-layer: the same as above. Partial rows are discarded and no release is required afterwards.
- Per-buffer state: EMPTY -> FILLING -> ARMED -> EMPTY.
- Top FSM states: IDLE, FILL, DRAIN.
- IDLE:
  - layer_start with num_neurons>0 latches the count, clears neuron_cnt, sets busy=1 and goes to FILL.
  - layer_start with num_neurons=0 pulses layer_loaded the next cycle and stays in IDLE.
- FILL, wr_ready: wr_ready = (target buffer EMPTY or FILLING) and neurons_remaining>0.
- FILL, accepted byte (wr_valid&&wr_ready):
  - data[elem_cnt] <= wr_data; elem_cnt increments.
  - Buffer becomes FILLING on the first byte.
- FILL, row completion, when wr_last is accepted or elem_cnt==MAX_LEN-1 is accepted:
  - data_len <= elem_cnt+1 and neuron_idx <= neuron_cnt.
  - in_use <= 1 on the same edge, so it is visible the cycle after the last byte.
  - The buffer becomes ARMED; elem_cnt clears, neuron_cnt increments and the target advances w1->w2->w3->w1.
- Overflow: completion at MAX_LEN without wr_last sets err_overflow. Subsequent bytes up to and including wr_last are accepted and dropped (wr_ready=1, no buffer write).
- Target stall: if the target buffer is ARMED, wr_ready=0 until its release arrives.
- Release:
  - A release_wN pulse while wN is ARMED clears in_use on the next edge and returns the buffer to EMPTY.
  - data, data_len and neuron_idx hold until overwritten.
  - A release while the buffer is not ARMED is ignored.
- Same-cycle release and byte write: when release of the target buffer coincides with a byte write, the release is taken first and the byte is written in the following cycle. wr_ready is registered from the current state, so no combinational path exists from release to wr_ready.
- Multiple releases in one cycle: all are honoured.
- Last row: after the last neuron's row is armed, layer_loaded pulses once and the FSM goes to DRAIN.
- DRAIN: wr_ready=0. When all three buffers are EMPTY, busy=0 and the FSM returns to IDLE.
- layer_start outside IDLE is ignored.
- Widths: elem_cnt is $clog2(MAX_LEN)+1 bits; data_len is zero-extended into the meta_data field.

Optional Feature:
- Macro: ACCEL_WFEED_STATS_EN.
- When defined, adds output stall_cycles[15:0]. It counts cycles in FILL where wr_valid=1 and wr_ready=0, saturates at 16'hFFFF, and clears on Rst and on layer_start accepted from IDLE.
- When undefined, the port and counter are absent; all other behaviour is identical.

Test Plan:
1. Rows to three buffers:
   - Stimulus: layer_start, num_neurons=3; stream {03,04,05*}, {06,07,08*}, {09,0A,0B*} (* = wr_last), no releases.
   - Response: w1.data[0..2]=03,04,05 with data_len=3, neuron_idx=0; w2 holds 06,07,08 with idx=1; w3 holds 09,0A,0B with idx=2.
   - Each in_use rises the cycle after its bias byte; layer_loaded pulses once; busy stays 1.
2. Recycle stall:
   - Stimulus: num_neurons=4 with w1 not released; 4th row offered.
   - Response: wr_ready=0. One cycle after release_w1, w1.in_use=0; the next cycle wr_ready=1. The row lands in w1 with neuron_idx=3.
3. Drain:
   - Stimulus: release w1, w2, w3 in the same cycle after a 3-neuron layer.
   - Response: all in_use=0 next edge; busy=0 and IDLE; a new layer_start is accepted.
4. Overflow:
   - Stimulus: MAX_LEN=4; row of 6 bytes, last on the 6th.
   - Response: data_len=4, err_overflow=1 and sticky; bytes 5–6 dropped; next row goes to w2 with neuron_idx=1.
5. Reset and spurious release:
   - Stimulus: Rst asserted after 2 bytes of the second row; then release_w2 with w2 EMPTY.
   - Response: all outputs zero after the reset edge; the spurious release has no effect; layer_start restarts at w1 with neuron_idx=0.
6. Stats (ACCEL_WFEED_STATS_EN):
   - Stimulus: hold wr_valid=1 for 7 cycles while w1 is ARMED.
   - Response: stall_cycles=7; cleared by the next layer_start.
